alpaca_mac_requant_axis: RTL and testbench

ALPACA_MAC_REQUANT_AXIS -- requirements
Module: alpaca_mac_requant_axis

---
 rtl/alpaca_mac_requant_axis.sv | 176 +++++++++++++++++
 tb/tb_alpaca_mac_requant_axis.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alpaca_mac_requant_axis.sv
// alpaca_mac_requant_axis
// Requantises a signed MAC result (FRAC_WIDTH+COEFF_FRAC_WID fractional bits)
// down to a WIDTH-bit sample with FRAC_WIDTH fractional bits: round half up,
// then saturate. AXI-Stream on both sides with tlast/tuser carried alongside.
// Datapath: input register -> skid register -> stage 1 (add rounding constant)
// -> stage 2 (shift + saturate, drives m_axis). s_axis_tready is a register, so
// m_axis_tready never reaches it combinationally. Saturated output beats are
// counted in a sticky flag and a saturating 16-bit counter.
module alpaca_mac_requant_axis #(
  parameter int WIDTH          = 16,
  parameter int FRAC_WIDTH     = 15,
  parameter int COEFF_WID      = 16,
  parameter int COEFF_FRAC_WID = 15,
  parameter int TUSER_W        = 8,
  localparam int MW            = WIDTH + COEFF_WID + 1,
  localparam int SH            = COEFF_FRAC_WID
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MW-1:0]      s_axis_tdata,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  input  logic [TUSER_W-1:0] s_axis_tuser,
  output logic               s_axis_tready,
  output logic [WIDTH-1:0]   m_axis_tdata,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  output logic [TUSER_W-1:0] m_axis_tuser,
  input  logic               m_axis_tready,
  input  logic               ovf_clr,
  output logic               ovf_sticky,
  output logic [15:0]        ovf_count
);

  // The output format must fit inside the sample word and the shift must be non-zero.
  if (FRAC_WIDTH >= WIDTH || SH < 1) begin : g_bad_params
    $error("alpaca_mac_requant_axis: unsupported FRAC_WIDTH/COEFF_FRAC_WID");
  end

  // Half an output LSB expressed at MAC scale, and the sample range at shifted scale.
  localparam logic [MW:0]        RND   = (MW+1)'(1) << (SH - 1);
  localparam logic signed [MW:0] R_MAX = (MW+1)'((64'd1 << (WIDTH - 1)) - 64'd1);
  localparam logic signed [MW:0] R_MIN = ~R_MAX;

  logic               ready_q, ready_d;
  logic               in_valid_q, in_valid_d;
  logic [MW-1:0]      in_data_q;
  logic               in_last_q;
  logic [TUSER_W-1:0] in_user_q;
  logic               skid_valid_q, skid_valid_d;
  logic [MW-1:0]      skid_data_q;
  logic               skid_last_q;
  logic [TUSER_W-1:0] skid_user_q;
  logic               s1_valid_q, s1_valid_d;
  logic signed [MW:0] s1_r_q;
  logic               s1_last_q;
  logic [TUSER_W-1:0] s1_user_q;
  logic               s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]   s2_data_q;
  logic               s2_last_q;
  logic [TUSER_W-1:0] s2_user_q;
  logic               s2_sat_q;
  logic               ovf_sticky_q, ovf_sticky_d;
  logic [15:0]        ovf_count_q, ovf_count_d;

  logic               accept, s2_adv, s1_adv, in_move, in_to_skid, ovf_fire;
  logic [MW-1:0]      src_data;
  logic               src_last;
  logic [TUSER_W-1:0] src_user;
  logic signed [MW:0] r_d, r_sh;
  logic [WIDTH-1:0]   q_d;
  logic               sat_d;

  // Handshake and occupancy: the skid entry is older than the input register, so it feeds stage 1 first.
  always_comb begin
    accept       = s_axis_tvalid && ready_q;
    s2_adv       = !s2_valid_q || m_axis_tready;
    s1_adv       = !s1_valid_q || s2_adv;
    in_move      = in_valid_q && (s1_adv || !skid_valid_q);
    in_to_skid   = in_valid_q && (s1_adv ? skid_valid_q : !skid_valid_q);
    skid_valid_d = in_to_skid || (skid_valid_q && !s1_adv);
    in_valid_d   = accept || (in_valid_q && !in_move);
    s1_valid_d   = s1_adv ? (skid_valid_q || in_valid_q) : s1_valid_q;
    s2_valid_d   = s2_adv ? s1_valid_q : s2_valid_q;
    // Ready only when a new beat is guaranteed a free input register next cycle.
    ready_d      = !(in_valid_d && skid_valid_d);
  end

  // Arithmetic: stage 1 adds the rounding constant, stage 2 shifts and clamps.
  always_comb begin
    src_data = skid_valid_q ? skid_data_q : in_data_q;
    src_last = skid_valid_q ? skid_last_q : in_last_q;
    src_user = skid_valid_q ? skid_user_q : in_user_q;
    r_d      = $signed({src_data[MW-1], src_data} + RND);
    r_sh     = s1_r_q >>> SH;
    sat_d    = 1'b0;
    q_d      = r_sh[WIDTH-1:0];
    if (r_sh > R_MAX) begin
      q_d   = {1'b0, {(WIDTH-1){1'b1}}};
      sat_d = 1'b1;
    end else if (r_sh < R_MIN) begin
      q_d   = {1'b1, {(WIDTH-1){1'b0}}};
      sat_d = 1'b1;
    end
  end

  // Overflow status: a clear request overrides a coincident saturated beat.
  always_comb begin
    ovf_fire     = s2_valid_q && m_axis_tready && s2_sat_q;
    ovf_sticky_d = ovf_sticky_q;
    ovf_count_d  = ovf_count_q;
    if (ovf_clr) begin
      ovf_sticky_d = 1'b0;
      ovf_count_d  = '0;
    end else if (ovf_fire) begin
      ovf_sticky_d = 1'b1;
      if (ovf_count_q != 16'hFFFF) ovf_count_d = ovf_count_q + 16'd1;
    end
  end

  // Control state: valids, ready, output tlast and overflow status are reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q      <= 1'b0;
      in_valid_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_last_q    <= 1'b0;
      ovf_sticky_q <= 1'b0;
      ovf_count_q  <= '0;
    end else begin
      ready_q      <= ready_d;
      in_valid_q   <= in_valid_d;
      skid_valid_q <= skid_valid_d;
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      if (s2_adv) s2_last_q <= s1_last_q;
      ovf_sticky_q <= ovf_sticky_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  // Payload registers: no reset needed, qualified by the valid bits above.
  always_ff @(posedge clk) begin
    if (accept) begin
      in_data_q <= s_axis_tdata;
      in_last_q <= s_axis_tlast;
      in_user_q <= s_axis_tuser;
    end
    if (in_to_skid) begin
      skid_data_q <= in_data_q;
      skid_last_q <= in_last_q;
      skid_user_q <= in_user_q;
    end
    if (s1_adv) begin
      s1_r_q    <= r_d;
      s1_last_q <= src_last;
      s1_user_q <= src_user;
    end
    if (s2_adv) begin
      s2_data_q <= q_d;
      s2_user_q <= s1_user_q;
      s2_sat_q  <= sat_d;
    end
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tdata  = s2_data_q;
  assign m_axis_tvalid = s2_valid_q;
  assign m_axis_tlast  = s2_last_q;
  assign m_axis_tuser  = s2_user_q;
  assign ovf_sticky    = ovf_sticky_q;
  assign ovf_count     = ovf_count_q;

endmodule

// File: tb/tb_alpaca_mac_requant_axis.sv
// Self-checking bench for alpaca_mac_requant_axis at default parameters.
// Expected samples come from an arithmetic reference (floor((x + 2^14) / 2^15),
// clamped to int16) or from a constant table; a queue holds accepted beats.
module tb_alpaca_mac_requant_axis;
  localparam int MW = 33;

  logic          clk = 1'b0;
  logic          rst;
  logic [MW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [7:0]    s_axis_tuser;
  logic [15:0]   m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [7:0]    m_axis_tuser;
  logic          ovf_clr, ovf_sticky;
  logic [15:0]   ovf_count;

  always #5 clk = ~clk;

  alpaca_mac_requant_axis #(
    .WIDTH(16), .FRAC_WIDTH(15), .COEFF_WID(16), .COEFF_FRAC_WID(15), .TUSER_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tready(m_axis_tready),
    .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
  );

  typedef struct {
    logic [15:0] d;
    logic        last;
    logic [7:0]  user;
    bit          sat;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [MW-1:0] din;
    logic          last;
    logic [7:0]    user;
    logic [15:0]   exp_d;
    bit            exp_sat;
  } vec_t;

  int   checks = 0, failures = 0, cyc = 0;
  int   n_acc = 0, n_fire = 0, n_sat_fire = 0;
  exp_t sb[$];
  bit   lat_chk = 0, last_acc = 0;
  bit   prev_stall = 0;
  logic [15:0] prev_d;
  logic        prev_last;
  logic [7:0]  prev_user;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: round half toward +inf at 2^-15, then clamp to the int16 range.
  function automatic exp_t model(input logic [MW-1:0] din, input logic last, input logic [7:0] user);
    exp_t e;
    longint v, num, q;
    v   = longint'($signed(din));
    num = v + 16384;
    if (num >= 0) q = num / 32768;
    else          q = -((-num + 32767) / 32768);
    e.sat = 1'b0;
    if (q > 32767) begin
      q = 32767; e.sat = 1'b1;
    end else if (q < -32768) begin
      q = -32768; e.sat = 1'b1;
    end
    e.d = q[15:0]; e.last = last; e.user = user; e.acc_cyc = 0;
    return e;
  endfunction

  function automatic logic [MW-1:0] rand_data();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 2))
      0:       return {{12{r[20]}}, r[20:0]};
      1:       return {r[31], r[31:0]};
      default: return r[MW-1:0];
    endcase
  endfunction

  // One clock: observe handshakes at the falling edge, then let a rising edge pass.
  task automatic step(input bit use_exp = 1'b0, input logic [15:0] xd = '0, input bit xsat = 1'b0);
    exp_t e;
    bit   acc, fire;
    acc  = !rst && s_axis_tvalid && s_axis_tready;
    fire = !rst && m_axis_tvalid && m_axis_tready;
    last_acc = acc;
    if (!rst && prev_stall) begin
      chk("hold_tvalid", m_axis_tvalid, 1);
      chk("hold_tdata", m_axis_tdata, prev_d);
      chk("hold_tlast", m_axis_tlast, prev_last);
      chk("hold_tuser", m_axis_tuser, prev_user);
    end
    if (fire) begin
      n_fire++;
      if (sb.size() == 0) begin
        chk("tvalid_without_pending_beat", m_axis_tvalid, 0);
      end else begin
        e = sb.pop_front();
        chk("tdata", m_axis_tdata, e.d);
        chk("tlast", m_axis_tlast, e.last);
        chk("tuser", m_axis_tuser, e.user);
        if (e.sat) n_sat_fire++;
        if (lat_chk) chk("latency", cyc - e.acc_cyc - 1, 2);
      end
    end
    if (acc) begin
      e = model(s_axis_tdata, s_axis_tlast, s_axis_tuser);
      if (use_exp) begin
        e.d = xd; e.sat = xsat;
      end
      e.acc_cyc = cyc;
      sb.push_back(e);
      n_acc++;
    end
    prev_stall = !rst && m_axis_tvalid && !m_axis_tready;
    prev_d = m_axis_tdata; prev_last = m_axis_tlast; prev_user = m_axis_tuser;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0;
    for (int k = 0; k < 50 && sb.size() > 0; k++) step();
    chk("drain_empty", sb.size(), 0);
    step();
    chk("idle_after_drain", m_axis_tvalid, 0);
  endtask

  vec_t tbl[10];
  int   nsat, i, nf0, na0, ns0, n;
  bit   wrap_checked;
  logic sr;

  initial begin
    tbl[0] = '{33'h0_0000_3FFF, 1'b0, 8'h01, 16'h0000, 1'b0};
    tbl[1] = '{33'h0_0000_4000, 1'b0, 8'h02, 16'h0001, 1'b0};
    tbl[2] = '{33'h0_0000_C000, 1'b1, 8'h03, 16'h0002, 1'b0};
    tbl[3] = '{33'h1_FFFF_C000, 1'b0, 8'h04, 16'h0000, 1'b0};
    tbl[4] = '{33'h1_FFFF_BFFF, 1'b0, 8'h05, 16'hFFFF, 1'b0};
    tbl[5] = '{33'h0_8000_0000, 1'b0, 8'h06, 16'h7FFF, 1'b1};
    tbl[6] = '{33'h1_8000_0000, 1'b1, 8'h07, 16'h8000, 1'b1};
    tbl[7] = '{33'h0_3FFF_BFFF, 1'b0, 8'h08, 16'h7FFF, 1'b0};
    tbl[8] = '{33'h0_3FFF_C000, 1'b0, 8'h09, 16'h7FFF, 1'b1};
    tbl[9] = '{33'h1_BFFF_C000, 1'b0, 8'h0A, 16'h8000, 1'b0};

    rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    s_axis_tuser = '0; m_axis_tready = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    repeat (3) step();
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_ovf_sticky", ovf_sticky, 0);
    chk("rst_ovf_count", ovf_count, 0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", s_axis_tready, 1);

    // Rounding and saturation table, ready held high, latency checked.
    m_axis_tready = 1'b1; lat_chk = 1'b1; nsat = 0;
    for (int k = 0; k < 10; k++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = tbl[k].din;
      s_axis_tlast = tbl[k].last; s_axis_tuser = tbl[k].user;
      step(1'b1, tbl[k].exp_d, tbl[k].exp_sat);
      chk("tbl_accept", last_acc, 1);
      nsat += int'(tbl[k].exp_sat);
    end
    drain();
    lat_chk = 1'b0;
    chk("tbl_ovf_count", ovf_count, nsat);
    chk("tbl_ovf_sticky", ovf_sticky, 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("clr_ovf_count", ovf_count, 0);
    chk("clr_ovf_sticky", ovf_sticky, 0);

    // Random traffic on both sides against the reference model.
    n = 0;
    for (int k = 0; k < 2000 && n < 300; k++) begin
      if (!s_axis_tvalid || last_acc) begin
        s_axis_tvalid = ($urandom_range(0, 9) < 7);
        s_axis_tdata  = rand_data();
        s_axis_tlast  = 1'($urandom_range(0, 1));
        s_axis_tuser  = 8'($urandom);
      end
      m_axis_tready = 1'($urandom_range(0, 1));
      step();
      if (last_acc) n++;
    end
    chk("rand_accepted", n, 300);
    drain();

    // Backpressure: indexed stream 0..99, tlast on 99, random downstream ready.
    i = 0; nf0 = n_fire;
    for (int k = 0; k < 1000 && i < 100; k++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = MW'(i * 30011 - 1500000);
      s_axis_tuser  = 8'(i);
      s_axis_tlast  = (i == 99);
      m_axis_tready = 1'($urandom_range(0, 1));
      sr = s_axis_tready;
      m_axis_tready = !m_axis_tready; #1;
      chk("no_comb_ready_path", s_axis_tready, sr);
      m_axis_tready = !m_axis_tready; #1;
      step();
      if (last_acc) i++;
    end
    chk("bp_accepted", i, 100);
    drain();
    chk("bp_out_count", n_fire - nf0, 100);

    // Full stall: continuous input, downstream never ready.
    m_axis_tready = 1'b0; na0 = n_acc;
    s_axis_tvalid = 1'b1; s_axis_tdata = rand_data(); s_axis_tlast = 1'b0; s_axis_tuser = 8'h40;
    for (int k = 0; k < 10; k++) begin
      step();
      if (last_acc) begin
        s_axis_tdata = rand_data(); s_axis_tuser = 8'(8'h41 + k);
      end
    end
    chk("stall_accepts", n_acc - na0, 4);
    chk("stall_ready_low", s_axis_tready, 0);
    nf0 = n_fire;
    drain();
    chk("stall_drain_count", n_fire - nf0, 4);

    // Reset with three beats in flight; nothing from before may emerge.
    m_axis_tready = 1'b0; na0 = n_acc; s_axis_tvalid = 1'b1;
    for (int k = 0; k < 10 && (n_acc - na0) < 3; k++) begin
      step();
      if (last_acc) begin
        s_axis_tdata = rand_data(); s_axis_tuser = 8'(8'h60 + k);
      end
    end
    chk("rms_accepts", n_acc - na0, 3);
    s_axis_tvalid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; sb.delete();
    chk("rms_m_tvalid", m_axis_tvalid, 0);
    m_axis_tready = 1'b1; s_axis_tvalid = 1'b1;
    s_axis_tdata = 33'h0_0123_4567; s_axis_tuser = 8'hA5; s_axis_tlast = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (last_acc) break;
    end
    chk("rms_new_accepted", last_acc, 1);
    nf0 = n_fire;
    drain();
    chk("rms_out_count", n_fire - nf0, 1);

    // Overflow counter limit and clear-versus-increment priority.
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("lim_start_count", ovf_count, 0);
    m_axis_tready = 1'b1; s_axis_tvalid = 1'b1;
    s_axis_tdata = 33'h0_8000_0000; s_axis_tlast = 1'b0; s_axis_tuser = 8'h77;
    ns0 = n_sat_fire; wrap_checked = 1'b0;
    for (int k = 0; k < 70000 && (n_sat_fire - ns0) < 65537; k++) begin
      step();
      if (!wrap_checked && (n_sat_fire - ns0) == 65536) begin
        chk("ovf_no_wrap", ovf_count, 16'hFFFF);
        wrap_checked = 1'b1;
      end
    end
    chk("lim_sat_beats", n_sat_fire - ns0, 65537);
    chk("ovf_limit_count", ovf_count, 16'hFFFF);
    chk("ovf_limit_sticky", ovf_sticky, 1);
    chk("clr_coincident_valid", m_axis_tvalid, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0; s_axis_tvalid = 1'b0;
    chk("clr_wins_count", ovf_count, 0);
    chk("clr_wins_sticky", ovf_sticky, 0);
    step();
    chk("count_after_clr", ovf_count, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
